uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO placed directly upstream of the UART transmitter half.
- Absorbs bursts from a producer (CPU bridge, protocol encoder) and feeds the UART's tx_data_i / tx_ready_i / tx_ack_o handshake one octet at a time.
- Reports fill level and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of byte slots; power of two, >= 2.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  system clock; all transitions on posedge clk.
- reset  input  1  asynchronous, active-low reset.
- wr_data_i  input  8  byte to enqueue.
- wr_valid_i  input  1  enqueue request, one byte per cycle.
- wr_full_o  output  1  queue full; writes in this cycle are dropped.
- level_o  output  AW+1  number of stored bytes, 0..DEPTH.
- overflow_o  output  1  sticky: a write was dropped.
- ovf_clear_i  input  1  clears overflow_o.
- tx_data_o  output  8  head byte; connects to UART tx_data_i.
- tx_ready_o  output  1  head valid; connects to UART tx_ready_i.
- tx_ack_i  input  1  UART transmitter idle; connects to UART tx_ack_o.

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-low on `reset`.
- Reset values: rd_ptr = wr_ptr = 0, level_o = 0, wr_full_o = 0, overflow_o = 0, tx_ready_o = 0, tx_data_o = 8'h00. Memory contents are not reset.
- Reset mid-operation discards all queued bytes. Any frame the UART has already latched is unaffected.
- Storage: DEPTH x 8 array, AW-bit read and write pointers wrapping modulo DEPTH. level_o is a separate AW+1-bit counter.
- Push: push = wr_valid_i && !wr_full_o. On push, mem[wr_ptr] <= wr_data_i and wr_ptr increments.
- Pop: pop = tx_ready_o && tx_ack_i. On pop, rd_ptr increments. The UART latches tx_data_o on that same edge.
- Single pop per frame: the UART drops tx_ack_i on the cycle after it accepts a byte. This guarantees one pop per frame; no extra guard logic.
- Level update: push only -> +1; pop only -> -1; both in one cycle -> unchanged.
- Full boundary: wr_full_o = (level_o == DEPTH). It is registered, so a write while full is dropped even if a pop happens in the same cycle. No bypass.
- Empty boundary: tx_ready_o = (level_o != 0).
  - A byte pushed into an empty queue gives tx_ready_o = 1 on the next cycle, so write-to-ready latency is 1 cycle.
  - Push and pop at the same time are impossible when empty, since pop requires tx_ready_o.
- tx_data_o = mem[rd_ptr], combinational from the registered pointer. It must stay stable while tx_ready_o && !pop.
- Overflow flag:
  - overflow_o is set on the cycle after wr_valid_i && wr_full_o.
  - ovf_clear_i clears it.
  - If set and clear occur in the same cycle, set wins.
- Pointer wrap: writing DEPTH+3 bytes with interleaved pops must preserve order across the wrap point.

Optional Feature:
- Macro: UART_TXQ_CRLF_EN.
- When defined, the drain side has a 2-state FSM, PASS and LF_PEND:
  - PASS: if the head byte is 8'h0A and the queue is non-empty, tx_data_o = 8'h0D. An accepted handshake (tx_ready_o && tx_ack_i) moves to LF_PEND without popping.
  - LF_PEND: tx_data_o = 8'h0A. An accepted handshake pops and returns to PASS.
  - Any other head byte passes through in PASS with a normal pop.
  - Reset forces PASS.
  - level_o counts stored bytes only; the inserted CR is not counted.
- When not defined: no FSM; bytes pass unmodified.

Test Plan:
- Reset, then write 8'h41, 8'h42, 8'h43 on consecutive cycles with tx_ack_i = 0 -> level_o = 3, tx_ready_o = 1, tx_data_o = 8'h41.
- Same setup, pulse tx_ack_i high for 1 cycle three times, 20 cycles apart -> tx_data_o steps 41, 42, 43; level_o ends at 0; tx_ready_o = 0.
- DEPTH = 16 with tx_ack_i = 0: write 17 bytes -> wr_full_o = 1 after the 16th; the 17th is dropped; overflow_o = 1. Then pulse ovf_clear_i together with another write -> overflow_o stays 1. Pulse clear alone -> overflow_o = 0.
- Connected to the UART (FREQ 1_000_000, BAUD 9600): write 8'h55, 8'hA3, then 20 more bytes over the pointer wrap -> the serial decoder sees the identical byte sequence with no duplicates or losses.
- Assert reset with level_o = 5 -> level_o = 0 and tx_ready_o = 0 immediately (asynchronous). The first byte after release is the first byte written after release.
- With UART_TXQ_CRLF_EN defined: write 8'h61, 8'h0A, 8'h62 -> the UART receives 61, 0D, 0A, 62; level_o decrements exactly 3 times.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter handshake; reports fill level and sticky overflow.
// Optional CR insertion before each LF when UART_TXQ_CRLF_EN is defined.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_full_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  input  logic          ovf_clear_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_ready_o,
  input  logic          tx_ack_i
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_full;
  logic          r_ready;
  logic          r_ovf;

  logic          w_push;
  logic          w_pop;
  logic          w_hs;
  logic [7:0]    w_head;
  logic [AW:0]   w_level_nxt;

  assign w_push = wr_valid_i && !r_full;
  assign w_hs   = r_ready && tx_ack_i;
  assign w_head = r_mem[r_rd_ptr];

`ifdef UART_TXQ_CRLF_EN
  typedef enum logic {PASS, LF_PEND} state_t;
  state_t r_state;

  // An LF at the head is sent twice: first as CR (no pop), then as LF (pop).
  assign w_pop = w_hs && ((r_state == LF_PEND) || (w_head != 8'h0A));

  always_comb begin
    tx_data_o = '0;
    if (r_ready) begin
      if (r_state == LF_PEND)     tx_data_o = 8'h0A;
      else if (w_head == 8'h0A)   tx_data_o = 8'h0D;
      else                        tx_data_o = w_head;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PASS;
    end else if (w_hs) begin
      case (r_state)
        PASS:    if (w_head == 8'h0A) r_state <= LF_PEND;
        LF_PEND: r_state <= PASS;
        default: r_state <= PASS;
      endcase
    end
  end
`else
  assign w_pop     = w_hs;
  assign tx_data_o = r_ready ? w_head : '0;
`endif

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + (AW+1)'(1);
      2'b01:   w_level_nxt = r_level - (AW+1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
  end

  // Full/ready are registered from the next level so they track level_o exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_ready  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
      r_ready <= (w_level_nxt != '0);
      if (wr_valid_i && r_full) r_ovf <= 1'b1;
      else if (ovf_clear_i)     r_ovf <= 1'b0;
    end
  end

  assign wr_full_o  = r_full;
  assign level_o    = r_level;
  assign overflow_o = r_ovf;
  assign tx_ready_o = r_ready;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus pushes expected bytes, a monitor checks each handshake.
module tb_uart_tx_queue;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] wr_data_i = '0;
  logic       wr_valid_i = 1'b0;
  logic       wr_full_o;
  logic [4:0] level_o;
  logic       overflow_o;
  logic       ovf_clear_i = 1'b0;
  logic [7:0] tx_data_o;
  logic       tx_ready_o;
  logic       tx_ack_i;
  logic       man_ack = 1'b0;
  logic       auto_ack = 1'b0;
  logic       uart_en = 1'b0;

  assign tx_ack_i = man_ack | auto_ack;

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_full_o(wr_full_o), .level_o(level_o), .overflow_o(overflow_o),
    .ovf_clear_i(ovf_clear_i), .tx_data_o(tx_data_o), .tx_ready_o(tx_ready_o),
    .tx_ack_i(tx_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dec_count = 0;
  logic [4:0] prev_level = '0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must present the next expected byte.
  always @(negedge clk) begin
    if (reset && tx_ready_o && tx_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data_o);
      end else begin
        chk("tx_byte", tx_data_o, exp_q.pop_front());
      end
    end
    if (level_o < prev_level) dec_count++;
    prev_level = level_o;
  end

  // UART model: idle -> ack high; after accepting a byte, ack low for a few busy cycles.
  initial begin
    logic hs;
    int   busy;
    busy = 0;
    forever begin
      @(negedge clk);
      hs = tx_ack_i && tx_ready_o;
      @(posedge clk);
      #1;
      if (hs) begin
        auto_ack = 1'b0;
        busy = 3;
      end else if (busy > 0) begin
        busy--;
      end else begin
        auto_ack = uart_en;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] b, input bit accept);
    wr_data_i  = b;
    wr_valid_i = 1'b1;
    if (accept) begin
`ifdef UART_TXQ_CRLF_EN
      if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(b);
    end
    step();
    wr_valid_i = 1'b0;
  endtask

  task automatic pulse_ack();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    uart_en = 1'b1;
    while ((level_o != 0 || exp_q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    chk(name, (n < 500), 1);
    uart_en = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_level", level_o, 0);
    chk("rst_ready", tx_ready_o, 0);
    chk("rst_full", wr_full_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_data", tx_data_o, 8'h00);
    reset = 1'b1;
    step();

    write(8'h41, 1); write(8'h42, 1); write(8'h43, 1);
    chk("burst_level", level_o, 3);
    chk("burst_ready", tx_ready_o, 1);
    chk("burst_head", tx_data_o, 8'h41);

    pulse_ack(); chk("pop1_level", level_o, 2); chk("pop1_head", tx_data_o, 8'h42);
    repeat (19) step();
    pulse_ack(); chk("pop2_level", level_o, 1); chk("pop2_head", tx_data_o, 8'h43);
    repeat (19) step();
    pulse_ack(); chk("pop3_level", level_o, 0);
    chk("empty_ready", tx_ready_o, 0);

    for (int i = 0; i < 16; i++) begin
      write(8'h80 + 8'(i), 1);
      if (i == 14) chk("full_at15", wr_full_o, 0);
    end
    chk("full_at16", wr_full_o, 1);
    chk("level_16", level_o, 16);
    chk("ovf_before", overflow_o, 0);
    write(8'h90, 0);
    chk("ovf_set", overflow_o, 1);
    chk("level_after_drop", level_o, 16);
    ovf_clear_i = 1'b1;
    write(8'h91, 0);
    ovf_clear_i = 1'b0;
    chk("ovf_set_wins", overflow_o, 1);
    ovf_clear_i = 1'b1;
    step();
    ovf_clear_i = 1'b0;
    chk("ovf_cleared", overflow_o, 0);
    drain("drain_full");
    chk("full_after_drain", wr_full_o, 0);

    uart_en = 1'b1;
    write(8'h55, 1);
    repeat (3) step();
    write(8'hA3, 1);
    for (int i = 0; i < 20; i++) begin
      repeat (3) step();
      write(8'h10 + 8'(7 * i), 1);
    end
    drain("drain_wrap");
    chk("wrap_no_ovf", overflow_o, 0);

    for (int i = 0; i < 5; i++) write(8'hC0 + 8'(i), 0);
    chk("pre_reset_level", level_o, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_level", level_o, 0);
    chk("async_rst_ready", tx_ready_o, 0);
    step();
    reset = 1'b1;
    step();
    write(8'h77, 1);
    chk("post_rst_head", tx_data_o, 8'h77);
    chk("post_rst_level", level_o, 1);
    pulse_ack();
    chk("post_rst_empty", level_o, 0);

    repeat (2) step();
    dec_count = 0;
    write(8'h61, 1); write(8'h0A, 1); write(8'h62, 1);
    drain("drain_lf");
    chk("lf_decrements", dec_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
